// File: rtl/onchip_mem_fill_check.sv
// Fills a word range of on-chip memory with a constant or incrementing pattern,
// or reads the range back and counts mismatches against the same pattern.
module onchip_mem_fill_check #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] pattern,
  input  logic              pattern_inc,
  output logic              busy,
  output logic              done,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [2:0] {IDLE, FILL, CHECK, DRAIN, DONE} state_e;

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              inc_q, inc_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              rdValid_q, rdValid_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic [DATA_W-1:0] rdExp_q, rdExp_d;

  logic [ADDR_W:0]   lenClamp;
  logic              lastWord;
  logic [ADDR_W-1:0] accAddr;
  logic [DATA_W-1:0] accData;
  logic              mismatch;

  assign lenClamp = (length > MaxLen) ? MaxLen : length;
  assign lastWord = ({1'b0, off_q} == (len_q - LenOne));
  assign accAddr  = base_q + off_q;
  assign accData  = inc_q ? (pat_q + DATA_W'(off_q)) : pat_q;
  assign mismatch = rdValid_q && (mem_readdata != rdExp_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (lenClamp == '0) state_d = DONE;
          else if (mode)      state_d = CHECK;
          else                state_d = FILL;
        end
      end
      FILL:    if (lastWord) state_d = DONE;
      CHECK:   if (lastWord) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == FILL) || (state_q == CHECK) || (state_q == DRAIN);
    done           = (state_q == DONE);
    mem_clken      = 1'b1;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = 4'h0;
    mem_address    = '0;
    mem_writedata  = '0;
    if (state_q == FILL) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_byteenable = 4'hF;
      mem_address    = accAddr;
      mem_writedata  = accData;
    end else if (state_q == CHECK) begin
      mem_chipselect = 1'b1;
      mem_byteenable = 4'hF;
      mem_address    = accAddr;
    end
  end

  // Compare stage: each read carries its address and expected word one cycle
  // forward to meet the memory's read data.
  always_comb begin
    base_d    = base_q;
    len_d     = len_q;
    pat_d     = pat_q;
    inc_d     = inc_q;
    off_d     = off_q;
    err_d     = err_q;
    first_d   = first_q;
    rdValid_d = (state_q == CHECK);
    rdAddr_d  = accAddr;
    rdExp_d   = accData;
    if (state_q == IDLE && start) begin
      base_d  = base_addr;
      len_d   = lenClamp;
      pat_d   = pattern;
      inc_d   = pattern_inc;
      off_d   = '0;
      err_d   = '0;
      first_d = '0;
    end else if (state_q == FILL || state_q == CHECK) begin
      off_d = off_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    first_d = rdAddr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      len_q     <= '0;
      pat_q     <= '0;
      inc_q     <= 1'b0;
      off_q     <= '0;
      err_q     <= '0;
      first_q   <= '0;
      rdValid_q <= 1'b0;
      rdAddr_q  <= '0;
      rdExp_q   <= '0;
    end else begin
      base_q    <= base_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      inc_q     <= inc_d;
      off_q     <= off_d;
      err_q     <= err_d;
      first_q   <= first_d;
      rdValid_q <= rdValid_d;
      rdAddr_q  <= rdAddr_d;
      rdExp_q   <= rdExp_d;
    end
  end

  assign error_count    = err_q;
  assign first_err_addr = first_q;

endmodule
